fft_pingpong_sequencer: RTL

//  Sequences a two-bank ping-pong sample buffer in front of the radix-2 FFT butterfly datapath.
//  - Write side: streams N samples per frame into the bank that is free.
//  - Compute side: issues log2(N) stages x N/2 butterfly-pair indices over the other, full bank.
//  - Frame k+1 loads while frame k is computed. Sits between the per-antenna sample stream and
//    the FFT core; replaces free-running pointer counters with a handshaked scheduler.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_stage_pair_counter.sv | 45 ++++
 rtl/fft_pingpong_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT ping-pong sequencer family.
package fft_pkg;

  typedef enum logic [1:0] {
    BANK_FREE      = 2'd0,
    BANK_FILLING   = 2'd1,
    BANK_FULL      = 2'd2,
    BANK_COMPUTING = 2'd3
  } bank_state_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fft_stage_pair_counter.sv
// Butterfly pair/stage index counter: pair wraps at PAIRS-1 and carries into stage.
module fft_stage_pair_counter #(
  parameter int PAIRS  = 8,
  parameter int STAGES = 4,
  parameter int PW     = 3,
  parameter int SW     = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [SW-1:0] stage,
  output logic [PW-1:0] pair,
  output logic          last
);

  localparam logic [PW:0]   PAIR_MAX  = (PW+1)'(PAIRS - 1);
  localparam logic [SW-1:0] STAGE_MAX = SW'(STAGES - 1);

  logic pair_last;
  logic stage_last;

  assign pair_last  = ({1'b0, pair} == PAIR_MAX);
  assign stage_last = (stage == STAGE_MAX);
  assign last       = pair_last & stage_last;

  // Index registers; only an accepted pair moves them, so a stall holds them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
      pair  <= '0;
    end else if (clear) begin
      stage <= '0;
      pair  <= '0;
    end else if (advance) begin
      if (pair_last) begin
        pair  <= '0;
        stage <= stage_last ? '0 : stage + SW'(1);
      end else begin
        pair  <= pair + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fft_pingpong_sequencer.sv
// Two-bank ping-pong scheduler: fills one bank with samples while butterfly
// indices are issued over the other, full bank.
module fft_pingpong_sequencer
  import fft_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  wr_en,
  output logic                                  wr_bank,
  output logic [$clog2(N)-1:0]                  wr_addr,
  output logic                                  bf_valid,
  input  logic                                  bf_ready,
  output logic                                  bf_bank,
  output logic [clog2_min1($clog2(N))-1:0]      bf_stage,
  output logic [$clog2(N)-2:0]                  bf_pair,
  output logic                                  frame_done,
  output logic                                  busy
);

  localparam int STAGES = $clog2(N);
  localparam int AW     = $clog2(N);
  localparam int SW     = clog2_min1(STAGES);
  localparam int PW     = AW - 1;
  localparam logic [AW-1:0] ADDR_MAX = AW'(N - 1);

  bank_state_t bank_state [0:1];
  bank_state_t bank_next  [0:1];
  bank_state_t wr_state;
  bank_state_t bf_state;
  logic        wr_last;
  logic        bf_fire;
  logic        bf_last;

  assign wr_state = bank_state[wr_bank];
  assign bf_state = bank_state[bf_bank];

  // Handshakes come straight from registered state; reset_n gates in_ready during reset.
  assign in_ready = reset_n & enable & ((wr_state == BANK_FREE) | (wr_state == BANK_FILLING));
  assign wr_en    = in_valid & in_ready;
  assign wr_last  = wr_en & (wr_addr == ADDR_MAX);
  assign bf_valid = enable & (bf_state == BANK_COMPUTING);
  assign bf_fire  = bf_valid & bf_ready;
  assign busy     = (bank_state[0] != BANK_FREE) | (bank_state[1] != BANK_FREE);

  fft_stage_pair_counter #(
    .PAIRS  (N / 2),
    .STAGES (STAGES),
    .PW     (PW),
    .SW     (SW)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (~enable),
    .advance (bf_fire),
    .stage   (bf_stage),
    .pair    (bf_pair),
    .last    (bf_last)
  );

  // Next bank state; write and compute sides never own the same bank at once.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_next[b] = bank_state[b];
      if (!enable) begin
        bank_next[b] = BANK_FREE;
      end else if (wr_en && (wr_bank == 1'(b))) begin
        bank_next[b] = wr_last ? BANK_FULL : BANK_FILLING;
      end else if ((bf_bank == 1'(b)) && bf_fire && bf_last) begin
        bank_next[b] = BANK_FREE;
      end else if ((bf_bank == 1'(b)) && (bank_state[b] == BANK_FULL)) begin
        bank_next[b] = BANK_COMPUTING;
      end else begin
        bank_next[b] = bank_state[b];
      end
    end
  end

  // Bank states, write pointer, bank selects and the completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_state[0] <= BANK_FREE;
      bank_state[1] <= BANK_FREE;
      wr_bank       <= 1'b0;
      wr_addr       <= '0;
      bf_bank       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      bank_state <= bank_next;
      if (!enable) begin
        wr_bank    <= 1'b0;
        wr_addr    <= '0;
        bf_bank    <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else if (wr_en) begin
          wr_addr <= wr_addr + AW'(1);
        end
        if (bf_fire && bf_last) begin
          bf_bank <= ~bf_bank;
        end
        frame_done <= bf_fire & bf_last;
      end
    end
  end

endmodule
